// File: rtl/line_buffer_scheduler_pkg.sv
// Shared types and helpers for the line-buffer scheduler: bank geometry,
// frame state encoding and buffer-select masks.
package line_buffer_scheduler_pkg;

  localparam int NUM_BUFS = 4;
  localparam int KERNEL_H = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // One-hot select of a single buffer in the bank.
  function automatic logic [NUM_BUFS-1:0] buf_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // The three buffers of the window, starting at the top row and wrapping mod 4.
  function automatic logic [NUM_BUFS-1:0] oe_mask(input logic [1:0] top);
    logic [NUM_BUFS-1:0] m;
    logic [1:0]          idx;
    m = 4'b0000;
    for (int k = 0; k < KERNEL_H; k++) begin
      idx    = top + 2'(k);
      m[idx] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/line_buffer_scheduler_if.sv
// Handshake and buffer-control bundle between the scheduler and its
// feature source, line-buffer bank and window consumer.
interface line_buffer_scheduler_if
  import line_buffer_scheduler_pkg::*;
#(
  parameter int LINE_W = 8
);
  localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BUFS-1:0] we;
  logic [AW-1:0]       wr_addr;
  logic                rd_valid;
  logic                out_ready;
  logic [NUM_BUFS-1:0] oe;
  logic [AW-1:0]       rd_addr;
  logic [1:0]          rd_top;
  logic                busy;
  logic                done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, we, wr_addr, rd_valid, oe, rd_addr, rd_top, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, we, wr_addr, rd_valid, oe, rd_addr, rd_top, busy, done
  );
endinterface

// File: rtl/line_buffer_scheduler_col.sv
// Modulo-LINE_W column counter with enable, clear and a wrap pulse that
// marks the enabled step from the last column back to zero.
module lb_col_counter #(
  parameter int LINE_W = 8,
  parameter int CW     = (LINE_W > 1) ? $clog2(LINE_W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  assign wrap = en && (count == CW'(LINE_W - 1));

  // Column position, cleared outside a frame.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= {CW{1'b0}};
    end else if (wrap) begin
      count <= {CW{1'b0}};
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/line_buffer_scheduler.sv
// Frame sequencer for the 4-entry circular line-buffer bank: steers writes,
// issues 3-row window-column reads, and blocks overwrite of unread lines.
module line_buffer_scheduler
  import line_buffer_scheduler_pkg::*;
#(
  parameter int LINE_W = 8,
  parameter int IMG_H  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  line_buffer_scheduler_if.slave  bus
);

  localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  // Wide enough for rd_row + NUM_BUFS without overflow.
  localparam int LW = $clog2(IMG_H + NUM_BUFS + 1);

  state_e          state_r;
  logic [LW-1:0]   wr_line_r;
  logic [LW-1:0]   rd_row_r;
  logic [1:0]      rd_top_r;
  logic [AW-1:0]   wr_col_s;
  logic [AW-1:0]   rd_col_s;
  logic            wr_wrap_s;
  logic            rd_wrap_s;
  logic            run_s;
  logic            clr_s;
  logic            in_ready_s;
  logic            rd_valid_s;
  logic            wr_fire_s;
  logic            rd_fire_s;
  logic            last_read_s;

  assign run_s       = (state_r == RUN);
  assign clr_s       = !run_s;
  assign in_ready_s  = run_s && (wr_line_r < LW'(IMG_H))
                       && (wr_line_r < rd_row_r + LW'(NUM_BUFS));
  assign rd_valid_s  = run_s && (rd_row_r < LW'(IMG_H - 2))
                       && (wr_line_r >= rd_row_r + LW'(KERNEL_H));
  assign wr_fire_s   = bus.in_valid && in_ready_s;
  assign rd_fire_s   = rd_valid_s && bus.out_ready;
  assign last_read_s = rd_fire_s && rd_wrap_s && (rd_row_r == LW'(IMG_H - 3));

  lb_col_counter #(.LINE_W(LINE_W), .CW(AW)) u_wr_col (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .en    (wr_fire_s),
    .count (wr_col_s),
    .wrap  (wr_wrap_s)
  );

  lb_col_counter #(.LINE_W(LINE_W), .CW(AW)) u_rd_col (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .en    (rd_fire_s),
    .count (rd_col_s),
    .wrap  (rd_wrap_s)
  );

  // Frame state: start is only honoured from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= bus.start ? RUN : IDLE;
        RUN:     state_r <= last_read_s ? FIN : RUN;
        FIN:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Line completion and row retirement update independently, so both land
  // when they coincide.
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      wr_line_r <= {LW{1'b0}};
      rd_row_r  <= {LW{1'b0}};
      rd_top_r  <= 2'd0;
    end else begin
      if (wr_fire_s && wr_wrap_s) begin
        wr_line_r <= wr_line_r + LW'(1);
      end
      if (rd_fire_s && rd_wrap_s) begin
        rd_row_r <= rd_row_r + LW'(1);
        rd_top_r <= rd_top_r + 2'd1;
      end
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.we       = wr_fire_s ? buf_onehot(wr_line_r[1:0]) : {NUM_BUFS{1'b0}};
  assign bus.wr_addr  = wr_col_s;
  assign bus.rd_valid = rd_valid_s;
  assign bus.oe       = rd_fire_s ? oe_mask(rd_top_r) : {NUM_BUFS{1'b0}};
  assign bus.rd_addr  = rd_col_s;
  assign bus.rd_top   = rd_top_r;
  assign bus.busy     = (state_r != IDLE);
  assign bus.done     = (state_r == FIN);

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Directed bench for line_buffer_scheduler (LINE_W=8, IMG_H=8): reset, prime,
// full stall, rotation, coincident line/row events and mid-frame reset.
module tb_line_buffer_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   wcount;
  int   rcount;
  int   nacc;

  line_buffer_scheduler_if #(.LINE_W(8)) bus ();

  line_buffer_scheduler #(.LINE_W(8), .IMG_H(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_oe(input int top);
    case (top)
      0:       return 4'b0111;
      1:       return 4'b1110;
      2:       return 4'b1101;
      3:       return 4'b1011;
      default: return 4'b0000;
    endcase
  endfunction

  // Finishes the current frame from (wcount, rcount) with random out_ready.
  task automatic run_frame();
    int  n;
    int  exp_ir;
    int  exp_rv;
    for (n = 0; n < 2000 && rcount < 48; n++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ir = int'(wcount < 64 && (wcount / 8) < (rcount / 8) + 4);
      exp_rv = int'((rcount / 8) < 6 && (wcount / 8) >= (rcount / 8) + 3);
      chk("run_in_ready", 32'(bus.in_ready), 32'(exp_ir));
      chk("run_rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
      chk("run_done_low", 32'(bus.done), 32'd0);
      if (bus.in_ready && bus.in_valid) begin
        chk("run_we", 32'(bus.we), 32'(4'b0001 << ((wcount / 8) % 4)));
        chk("run_wr_addr", 32'(bus.wr_addr), 32'(wcount % 8));
        wcount++;
      end else begin
        chk("run_we_idle", 32'(bus.we), 32'd0);
      end
      if (bus.rd_valid && bus.out_ready) begin
        chk("run_oe", 32'(bus.oe), 32'(exp_oe((rcount / 8) % 4)));
        chk("run_rd_top", 32'(bus.rd_top), 32'((rcount / 8) % 4));
        chk("run_rd_addr", 32'(bus.rd_addr), 32'(rcount % 8));
        rcount++;
      end else begin
        chk("run_oe_idle", 32'(bus.oe), 32'd0);
      end
      tick();
    end
    chk("frame_reads", 32'(rcount), 32'd48);
    chk("frame_writes", 32'(wcount), 32'd64);
    bus.out_ready = 1'b1;
    #1;
    chk("fin_done", 32'(bus.done), 32'd1);
    chk("fin_busy", 32'(bus.busy), 32'd1);
    chk("fin_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    tick();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_oe", 32'(bus.oe), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_addrs", 32'({bus.wr_addr, bus.rd_addr, bus.rd_top}), 32'd0);
    tick();

    // Frame 1: prime, full stall, drain one row, then finish the frame.
    rst          = 1'b0;
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.start = 1'b0;
    #1;
    chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    chk("start_busy", 32'(bus.busy), 32'd1);
    tick();
    for (int i = 0; i < 24; i++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("prime_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("prime_we", 32'(bus.we), 32'(4'b0001 << (i / 8)));
      chk("prime_wr_addr", 32'(bus.wr_addr), 32'(i % 8));
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("first_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("first_oe", 32'(bus.oe), 32'b0111);
    chk("first_rd_top", 32'(bus.rd_top), 32'd0);
    chk("first_rd_addr", 32'(bus.rd_addr), 32'd0);
    tick();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    nacc          = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.in_ready) nacc++;
      tick();
    end
    chk("stall_accepts", 32'(nacc), 32'd8);
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_rd_valid", 32'(bus.rd_valid), 32'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int r = 1; r < 8; r++) begin
      #1;
      chk("drain_oe", 32'(bus.oe), 32'b0111);
      chk("drain_rd_addr", 32'(bus.rd_addr), 32'(r));
      chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    chk("retire_in_ready", 32'(bus.in_ready), 32'd1);
    chk("retire_we", 32'(bus.we), 32'b0001);
    chk("retire_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("retire_rd_top", 32'(bus.rd_top), 32'd1);
    tick();
    wcount = 33;
    rcount = 8;
    run_frame();

    // Frame 2: reset after 20 writes discards the partial frame.
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("f2_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_we_oe", 32'({bus.we, bus.oe}), 32'd0);
    chk("mid_rst_state", 32'({bus.busy, bus.done, bus.rd_valid}), 32'd0);
    chk("mid_rst_addrs", 32'({bus.wr_addr, bus.rd_addr, bus.rd_top}), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    // Frame 3: line completion coinciding with row retirement, twice.
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      #1;
      chk("f3_prime_we", 32'(bus.we), 32'(4'b0001 << (i / 8)));
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("same_in_ready", 32'(bus.in_ready), 32'd1);
      chk("same_rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("same_we", 32'(bus.we), (i < 8) ? 32'b1000 : 32'b0001);
      chk("same_oe", 32'(bus.oe), (i < 8) ? 32'b0111 : 32'b1110);
      chk("same_rd_top", 32'(bus.rd_top), 32'(i / 8));
      chk("same_addrs", 32'({bus.wr_addr, bus.rd_addr}), 32'({3'(i % 8), 3'(i % 8)}));
      tick();
    end
    bus.out_ready = 1'b0;
    #1;
    chk("after_same_we", 32'(bus.we), 32'b0010);
    chk("after_same_rd_top", 32'(bus.rd_top), 32'd2);
    chk("after_same_rd_valid", 32'(bus.rd_valid), 32'd1);
    tick();
    wcount = 41;
    rcount = 16;
    run_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
